// File: rtl/timer_responder.sv
// Memory-mapped countdown timer on the system bridge; raises irq when the programmed count expires.
// Latency: reads are combinational, writes land on the clock edge, and irq comes straight from registers.
// Backpressure: none; every access completes in one cycle.
`timescale 1ns/1ps
module timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO  = 2'd1;

  state_t      state, state_nxt;
  ctrl_t       ctrl, ctrl_nxt;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_flag, flag_nxt;

  logic [1:0]  off;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        unused_bits;

  assign off       = addr[3:2];
  assign ctrl_wr   = sel & we & (off == OFF_CTRL);
  assign preset_wr = sel & we & (off == OFF_PRESET);

  // The bridge already qualifies the range, so the upper and byte-lane bits are don't-care.
  assign unused_bits = ^{addr[31:4], addr[1:0], BASE_ADDR};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl_nxt  = ctrl;
    count_nxt = count;
    flag_nxt  = irq_flag;

    // Auto-reload makes the flag a single-cycle pulse; INT below re-arms it.
    if (ctrl.mode == MODE_AUTO) begin
      flag_nxt = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (ctrl.en) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl.en) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt = '0;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        state_nxt = ST_IDLE;
        flag_nxt  = 1'b1;
        if (ctrl.mode != MODE_AUTO) begin
          ctrl_nxt.en = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // A CPU store to CTRL overrides whatever the FSM did to EN and the flag this cycle.
    if (ctrl_wr) begin
      ctrl_nxt = ctrl_t'(wdata[3:0]);
      flag_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      ctrl     <= ctrl_nxt;
      count    <= count_nxt;
      irq_flag <= flag_nxt;
      if (preset_wr) begin
        preset <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_CTRL:   rdata = {28'd0, ctrl};
        OFF_PRESET: rdata = preset;
        OFF_COUNT:  rdata = count;
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = ctrl.im & irq_flag;

endmodule

// File: tb/tb_timer_responder.sv
// Bench for timer_responder: vector table, directed corner sequences, then random traffic against a timeline model.
`timescale 1ns/1ps
module tb_timer_responder;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = BASE;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_responder #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Model: register contents plus a run position counted in edges since the reload
  // (-1 idle, 0 reloading, 1..len counting, len+1 expiry edge).
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  longint      m_run, m_len;

  task automatic model_reset();
    m_en = 1'b0; m_im = 1'b0; m_mode = 2'd0; m_flag = 1'b0;
    m_preset = '0; m_count = '0; m_run = -1; m_len = 1;
  endtask

  task automatic model_step();
    logic        cw, pw, at_int;
    longint      run_n, len_n;
    logic [31:0] cnt_n;
    cw     = sel && we && (addr[3:2] == 2'd0);
    pw     = sel && we && (addr[3:2] == 2'd1);
    at_int = (m_run == m_len + 1);
    run_n  = m_run;
    len_n  = m_len;
    cnt_n  = m_count;
    if (m_run < 0) begin
      if (m_en) run_n = 0;
    end else if (m_run == 0) begin
      cnt_n = m_preset;
      len_n = (m_preset == 0) ? 64'sd1 : longint'(m_preset);
      run_n = 1;
    end else if (at_int || !m_en) begin
      run_n = -1;
    end else begin
      cnt_n = 32'(m_len - m_run);
      run_n = m_run + 1;
    end
    if (cw)                 m_flag = 1'b0;
    else if (at_int)        m_flag = 1'b1;
    else if (m_mode == 2'd1) m_flag = 1'b0;
    if (cw) begin
      m_en = wdata[0]; m_mode = wdata[2:1]; m_im = wdata[3];
    end else if (at_int && m_mode != 2'd1) begin
      m_en = 1'b0;
    end
    if (pw) m_preset = wdata;
    m_run = run_n; m_len = len_n; m_count = cnt_n;
  endtask

  function automatic logic [31:0] model_rdata();
    if (!sel) return '0;
    case (addr[3:2])
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic w, input logic [3:0] off, input logic [31:0] d);
    sel = s; we = w; addr = BASE | 32'(off); wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    drive(1'b1, 1'b1, off, d);
    tick();
  endtask

  task automatic rd(input logic [3:0] off);
    drive(1'b1, 1'b0, off, '0);
    tick();
  endtask

  typedef struct {
    logic        sel;
    logic        we;
    logic [3:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] r, r2;

    // One-shot, PRESET=3, IM=1: count 3,2,1,0 after edges 2..5, irq from edge 6 until CTRL is written.
    vecs[0]  = '{1'b1, 1'b1, 4'h4, 32'd3, 32'd3, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'h0, 32'd9, 32'd9, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'h8, 32'd0, 32'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'h8, 32'd0, 32'd3, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'h8, 32'd0, 32'd2, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'h8, 32'd0, 32'd1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 4'h8, 32'd0, 32'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 32'd0, 32'd8, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 32'd0, 32'd8, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 4'h0, 32'd0, 32'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0};

    model_reset();

    // Reset state: every offset reads 0.
    for (int o = 0; o < 4; o++) begin
      drive(1'b1, 1'b0, 4'(o * 4), '0);
      #1;
      chk($sformatf("rst_rd_off%0d", o * 4), rdata, 32'd0);
    end
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset asserted mid-count clears everything at once.
    wr(4'h4, 32'd100);
    wr(4'h0, 32'd1);
    repeat (10) rd(4'h8);
    chk("pre_rst_count", rdata, 32'd92);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_count", rdata, 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    drive(1'b1, 1'b0, 4'h0, '0); #1;
    chk("midrst_ctrl", rdata, 32'd0);
    drive(1'b1, 1'b0, 4'h4, '0); #1;
    chk("midrst_preset", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) rd(4'h8);
    chk("postrst_idle_count", rdata, 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].sel, vecs[i].we, vecs[i].off, vecs[i].wdata);
      tick();
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Auto-reload, PRESET=2: pulses on edges 5,10,15,20; then stop mid-count.
    wr(4'h4, 32'd2);
    wr(4'h0, 32'd11);
    for (int i = 1; i <= 22; i++) begin
      rd(4'h8);
      chk($sformatf("m1_irq_e%0d", i), 32'(irq), (i % 5 == 0) ? 32'd1 : 32'd0);
    end
    chk("m1_reload_count", rdata, 32'd2);
    wr(4'h0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      rd(4'h8);
      chk($sformatf("m1_frozen_count%0d", i), rdata, 32'd1);
      chk($sformatf("m1_frozen_irq%0d", i), 32'(irq), 32'd0);
    end

    // PRESET=0, one-shot: irq after edge 4.
    wr(4'h4, 32'd0);
    wr(4'h0, 32'd9);
    for (int i = 1; i <= 4; i++) begin
      rd(4'h8);
      chk($sformatf("p0_irq_e%0d", i), 32'(irq), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("p0_count", rdata, 32'd0);
    rd(4'h0);
    chk("p0_irq_hold", 32'(irq), 32'd1);
    chk("p0_en_cleared", rdata, 32'd8);
    wr(4'h0, 32'd0);
    chk("p0_irq_clr", 32'(irq), 32'd0);
    // Same with IM=0: flag set silently, and a later IM-only write clears it.
    wr(4'h0, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      rd(4'h0);
      chk($sformatf("p0_im0_irq_e%0d", i), 32'(irq), 32'd0);
    end
    chk("p0_im0_ctrl", rdata, 32'd0);
    wr(4'h0, 32'd8);
    chk("p0_im_only_irq", 32'(irq), 32'd0);
    rd(4'h0);
    rd(4'h0);
    chk("p0_im_only_irq_later", 32'(irq), 32'd0);
    chk("p0_im_only_ctrl", rdata, 32'd8);
    wr(4'h0, 32'd0);

    // PRESET rewrite during CNT is picked up only at the next reload.
    wr(4'h4, 32'd10);
    wr(4'h0, 32'd11);
    for (int i = 1; i <= 7; i++) rd(4'h8);
    chk("pc_count5", rdata, 32'd5);
    wr(4'h4, 32'd50);
    chk("pc_preset_coherent", rdata, 32'd50);
    rd(4'h8); chk("pc_count3", rdata, 32'd3);
    rd(4'h8); chk("pc_count2", rdata, 32'd2);
    rd(4'h8);
    rd(4'h8); chk("pc_count0", rdata, 32'd0);
    rd(4'h8); chk("pc_irq_pulse", 32'(irq), 32'd1);
    rd(4'h8); chk("pc_irq_end", 32'(irq), 32'd0);
    rd(4'h8); chk("pc_reload50", rdata, 32'd50);
    rd(4'h8); chk("pc_count49", rdata, 32'd49);
    wr(4'h0, 32'd0);
    rd(4'h8); chk("pc_stop48", rdata, 32'd48);

    // Stores that must not change anything.
    drive(1'b0, 1'b1, 4'h0, 32'hF); tick();
    chk("nosel_ctrl_rdata", rdata, 32'd0);
    drive(1'b0, 1'b1, 4'h4, 32'd77); tick();
    chk("nosel_preset_rdata", rdata, 32'd0);
    wr(4'h8, 32'd123);
    chk("ro_count_write", rdata, 32'd48);
    wr(4'hC, 32'd456);
    chk("unmapped_write", rdata, 32'd0);
    rd(4'h0); chk("ign_ctrl", rdata, 32'd0);
    rd(4'h4); chk("ign_preset", rdata, 32'd50);
    rd(4'h8); chk("ign_count", rdata, 32'd48);

    // EN cleared during LOAD: COUNT still loads, then the FSM parks.
    wr(4'h4, 32'd7);
    wr(4'h0, 32'd1);
    rd(4'h8); chk("ld_clr_before", rdata, 32'd48);
    wr(4'h0, 32'd0);
    rd(4'h8); chk("ld_clr_loaded", rdata, 32'd7);
    rd(4'h8);
    rd(4'h8); chk("ld_clr_held", rdata, 32'd7);

    // CTRL write in the INT cycle: CPU EN wins, flag cleared, timer reloads.
    wr(4'h4, 32'd1);
    wr(4'h0, 32'd9);
    rd(4'h8);
    rd(4'h8); chk("intw_count1", rdata, 32'd1);
    rd(4'h8); chk("intw_count0", rdata, 32'd0);
    wr(4'h0, 32'd9);
    chk("intw_ctrl", rdata, 32'd9);
    chk("intw_irq", 32'(irq), 32'd0);
    rd(4'h8); chk("intw_irq_next", 32'(irq), 32'd0);
    rd(4'h8); chk("intw_reload", rdata, 32'd1);
    rd(4'h8);
    rd(4'h0);
    chk("intw_irq_second", 32'(irq), 32'd1);
    chk("intw_en_cleared", rdata, 32'd8);
    wr(4'h0, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom;
      r2 = $urandom;
      sel   = (r[5:4] != 2'd0);
      we    = (r[2:0] == 3'd0);
      addr  = {r2[31:4], r[7:6], r2[1:0]};
      wdata = (r[7:6] == 2'd1) ? (r2 % 9) : $urandom;
      tick();
      chk($sformatf("rnd%0d_rdata", n), rdata, model_rdata());
      chk($sformatf("rnd%0d_irq", n), 32'(irq), 32'(m_im & m_flag));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
